gcd_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one GCD unit among `NUM_REQ` requester channels. It accepts one operand pair at a time from the granted requester, issues it to the GCD unit's operand handshake, and collects the result. It then returns the result on that requester's response channel. It sits between the client ports and the single GCD datapath/control pair, and allows only one operation in flight.

---
 rtl/gcd_arbiter.sv | 87 ++++++++
 tb/tb_gcd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sequencer sharing one GCD unit among NUM_REQ requesters.
// Only one operation is in flight; results return on the granted requester's channel.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_val,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*W-1:0]       req_a,
  input  logic [NUM_REQ*W-1:0]       req_b,
  output logic [NUM_REQ-1:0]         resp_val,
  input  logic [NUM_REQ-1:0]         resp_rdy,
  output logic [W-1:0]               resp_data,
  output logic                       gcd_operands_val,
  input  logic                       gcd_operands_rdy,
  output logic [W-1:0]               gcd_a,
  output logic [W-1:0]               gcd_b,
  input  logic                       gcd_result_val,
  output logic                       gcd_result_rdy,
  input  logic [W-1:0]               gcd_result_bits,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] prio_ptr, pick, idx;
  logic [W-1:0] a_q, b_q, res_q;
  logic found;
  int s;
  // Scan upward from prio_ptr, wrapping, so the last-served channel ends up lowest.
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(prio_ptr) + k;
      idx = IW'(s >= NUM_REQ ? s - NUM_REQ : s);
      if (!found && req_val[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE  ? (found ? ISSUE : IDLE) :
                state == ISSUE ? (gcd_operands_rdy ? WAIT : ISSUE) :
                state == WAIT  ? (gcd_result_val ? RESP : WAIT) :
                                 (resp_rdy[grant_id] ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_ptr <= '0;
      grant_id <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_id <= pick;
        a_q <= req_a[int'(pick)*W +: W];
        b_q <= req_b[int'(pick)*W +: W];
      end
      if (state == WAIT && gcd_result_val) res_q <= gcd_result_bits;
      if (state == RESP && resp_rdy[grant_id])
        prio_ptr <= grant_id == IW'(NUM_REQ-1) ? '0 : grant_id + 1'b1;
    end
  end
  // Result ready outside RESP also flushes any result left over from before a reset.
  always_comb begin
    req_rdy = (state == IDLE && found) ? NUM_REQ'(1) << pick : '0;
    resp_val = state == RESP ? NUM_REQ'(1) << grant_id : '0;
    resp_data = res_q;
    gcd_operands_val = state == ISSUE;
    gcd_a = a_q;
    gcd_b = b_q;
    gcd_result_rdy = state != RESP;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: table-driven and sequence checks of gcd_arbiter against a GCD stub
// and a response scoreboard keyed by the granted channel.
module tb_gcd_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_val, req_rdy, resp_val, resp_rdy;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] resp_data, gcd_a, gcd_b, gcd_result_bits;
  logic gcd_operands_val, gcd_operands_rdy, gcd_result_val, gcd_result_rdy, busy;
  logic [1:0] grant_id;
  typedef struct {int ch; logic [W-1:0] res;} exp_t;
  typedef struct {int ch; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] r;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  int grant_log[$];
  logic [W-1:0] exp_res [N];
  logic [W-1:0] cur_a, cur_b;
  vec_t vt [7];
  int checks = 0, errors = 0;
  int stall = 0, lat = 2, stale_cnt = 0;
  logic st_busy, ophs, rshs, ov, stale;
  logic [W-1:0] st_res, oa, ob;
  int st_cnt;

  gcd_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_data(resp_data), .gcd_operands_val(gcd_operands_val),
    .gcd_operands_rdy(gcd_operands_rdy), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_result_val(gcd_result_val), .gcd_result_rdy(gcd_result_rdy),
    .gcd_result_bits(gcd_result_bits), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s timed out", n);
  endtask

  // GCD unit stub: not reset by the arbiter, so it can hold a stale result across a reset.
  initial begin
    gcd_operands_rdy = 1'b1;
    gcd_result_val = 1'b0;
    gcd_result_bits = '0;
    st_busy = 1'b0;
    st_res = '0;
    st_cnt = 0;
    forever begin
      @(negedge clk);
      ophs = gcd_operands_val && gcd_operands_rdy;
      rshs = gcd_result_val && gcd_result_rdy;
      stale = rshs && (!busy || gcd_operands_val);
      ov = gcd_operands_val;
      oa = gcd_a;
      ob = gcd_b;
      @(posedge clk);
      #1;
      if (rshs) st_busy = 1'b0;
      if (stale) stale_cnt++;
      if (ophs) begin
        st_busy = 1'b1;
        st_res = gcd_f(oa, ob);
        st_cnt = lat;
      end else if (st_busy && st_cnt > 0) st_cnt--;
      if (ov && stall > 0) stall--;
      gcd_result_val = st_busy && st_cnt == 0;
      gcd_result_bits = gcd_result_val ? st_res : '0;
      gcd_operands_rdy = !st_busy && stall == 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++)
        if (req_val[i] && req_rdy[i]) begin
          chk("req_rdy_onehot", req_rdy, 64'(1) << i);
          sb.push_back('{i, exp_res[i]});
          grant_log.push_back(i);
          cur_a = req_a[i*W +: W];
          cur_b = req_b[i*W +: W];
        end
      if (gcd_operands_val && gcd_operands_rdy) begin
        chk("gcd_a", gcd_a, cur_a);
        chk("gcd_b", gcd_b, cur_b);
      end
      if ((resp_val & resp_rdy) != 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp resp_val=%b expected none", resp_val);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_val", resp_val, 64'(1) << mon_e.ch);
          chk("resp_data", resp_data, mon_e.res);
          chk("grant_id", grant_id, mon_e.ch);
        end
      end
    end
  end

  task automatic wait_grant(input int ch);
    int t;
    t = 0;
    @(negedge clk);
    while (!(req_val[ch] && req_rdy[ch]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("grant");
    @(posedge clk);
    #1;
    req_val[ch] = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("drain");
  endtask

  task automatic set_req(input int ch, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r);
    exp_res[ch] = r;
    req_a[ch*W +: W] = a;
    req_b[ch*W +: W] = b;
    req_val[ch] = 1'b1;
  endtask

  task automatic apply(input int ch, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r);
    @(posedge clk);
    #1;
    set_req(ch, a, b, r);
    wait_grant(ch);
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int t, st0;
    req_val = '0;
    resp_rdy = '1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    vt[0] = '{2, 16'd27, 16'd15, 16'd3};
    vt[1] = '{3, 16'd5, 16'd0, 16'd5};
    vt[2] = '{0, 16'd12, 16'd8, 16'd4};
    vt[3] = '{1, 16'd49, 16'd14, 16'd7};
    vt[4] = '{0, 16'd0, 16'd7, 16'd7};
    vt[5] = '{3, 16'd65535, 16'd255, 16'd255};
    vt[6] = '{1, 16'd100, 16'd75, 16'd25};
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_op_val", gcd_operands_val, 0);
    chk("rst_res_rdy", gcd_result_rdy, 1);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_gcd_a", gcd_a, 0);
    chk("rst_gcd_b", gcd_b, 0);
    chk("rst_resp_data", resp_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int v = 0; v < 7; v++) apply(vt[v].ch, vt[v].a, vt[v].b, vt[v].r);

    // Fairness: every channel requests continuously from prio_ptr = 0.
    do_reset();
    grant_log.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 16'd12, 16'd8, 16'd4);
    t = 0;
    while (grant_log.size() < 5 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout("fair_grants");
    @(posedge clk);
    #1 req_val = '0;
    wait_drain();
    for (int i = 0; i < 5; i++) chk("fair_order", grant_log[i], i % N);

    // Back-pressure on channel 1 while channel 3 waits.
    resp_rdy = 4'b1101;
    @(posedge clk);
    #1;
    set_req(1, 16'd49, 16'd14, 16'd7);
    set_req(3, 16'd10, 16'd4, 16'd2);
    wait_grant(1);
    t = 0;
    @(negedge clk);
    while (!resp_val[1] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("hold_resp");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_resp_val", resp_val, 4'b0010);
      chk("hold_resp_data", resp_data, 7);
      chk("hold_req_rdy", req_rdy, 0);
    end
    @(posedge clk);
    #1 resp_rdy = '1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_grant", req_rdy, 4'b1000);
    @(posedge clk);
    #1 req_val[3] = 1'b0;
    wait_drain();

    // GCD unit stalls operand ready for three cycles.
    stall = 3;
    @(posedge clk);
    #1;
    set_req(0, 16'd33, 16'd22, 16'd11);
    set_req(2, 16'd18, 16'd12, 16'd6);
    wait_grant(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_op_val", gcd_operands_val, 1);
      chk("stall_gcd_a", gcd_a, 33);
      chk("stall_gcd_b", gcd_b, 22);
      chk("stall_req_rdy", req_rdy, 0);
    end
    wait_grant(2);
    wait_drain();

    // Reset in WAIT; the late result must be flushed and never answered.
    lat = 8;
    st0 = stale_cnt;
    @(posedge clk);
    #1;
    set_req(0, 16'd100, 16'd75, 16'd25);
    wait_grant(0);
    t = 0;
    @(negedge clk);
    while (!(busy && !gcd_operands_val) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout("reach_wait");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_res_rdy", gcd_result_rdy, 1);
    chk("async_resp_val", resp_val, 0);
    sb.delete();
    #3 reset_n = 1'b1;
    t = 0;
    while (stale_cnt == st0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("stale_flushed", stale_cnt, st0 + 1);
    lat = 2;
    apply(1, 16'd9, 16'd6, 16'd3);
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
